// File: rtl/instr_fetch_if.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_if
//  Description : Fetch-side bus bundle: instruction memory port plus the
//                decode valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
interface instr_fetch_if #(
    parameter int ADDR_W = 12
);
    logic [ADDR_W-1:0] i_mem_addr;
    logic              i_mem_rd;
    logic [7:0]        i_mem_data;
    logic              instr_vld;
    logic              decode_rdy;
    logic [7:0]        instr_op;
    logic [7:0]        instr_imm;
    logic              instr_len2;
    logic [ADDR_W-1:0] instr_addr;
    logic [ADDR_W-1:0] next_addr;

    modport master (
        output i_mem_addr, i_mem_rd, instr_vld, instr_op, instr_imm,
               instr_len2, instr_addr, next_addr,
        input  i_mem_data, decode_rdy
    );

    modport slave (
        input  i_mem_addr, i_mem_rd, instr_vld, instr_op, instr_imm,
               instr_len2, instr_addr, next_addr,
        output i_mem_data, decode_rdy
    );
endinterface
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch
//  Description : Fetch stage: owns the PC, reads 1/2-byte instructions and
//                hands them to decode; redirects on JMP/CALL/RET.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch #(
    parameter int                ADDR_W   = 12,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  wire logic              clk,
    input  wire logic              reset,
    input  wire logic              fetch_en,
    input  wire logic              pc_branch,
    input  wire logic [ADDR_W-1:0] branch_addr,
    input  wire logic              ret_addr_en,
    input  wire logic [ADDR_W-1:0] ret_addr,
    instr_fetch_if.master          fif
);

    localparam logic [1:0] S_REQ  = 2'd0;
    localparam logic [1:0] S_OPD  = 2'd1;
    localparam logic [1:0] S_IMMD = 2'd2;
    localparam logic [1:0] S_OUT  = 2'd3;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_instr_addr;
    logic [7:0]        r_instr_op;
    logic [7:0]        r_instr_imm;
    logic              r_instr_len2;
    logic              w_redirect;
    logic [ADDR_W-1:0] w_redirect_addr;
    logic [ADDR_W-1:0] w_next_addr;
    logic              w_mem_rd;
    logic [ADDR_W-1:0] w_mem_addr;
    logic              w_instr_vld;

    assign w_redirect      = pc_branch | ret_addr_en;
    assign w_redirect_addr = pc_branch ? branch_addr : ret_addr;
    assign w_next_addr     = r_instr_addr + ADDR_W'(1)
                           + {{(ADDR_W-1){1'b0}}, r_instr_len2};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_REQ;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_redirect) begin
            w_state_nxt = S_REQ;
        end else begin
            case (r_state)
                S_REQ:   if (fetch_en) w_state_nxt = S_OPD;
                S_OPD:   w_state_nxt = fif.i_mem_data[7] ? S_IMMD : S_OUT;
                S_IMMD:  w_state_nxt = S_OUT;
                S_OUT:   if (fif.decode_rdy) w_state_nxt = fetch_en ? S_OPD : S_REQ;
                default: w_state_nxt = S_REQ;
            endcase
        end
    end

    // A redirect kills both the request and the presented instruction in the
    // same cycle, so neither wrong-path fetches nor wrong-path accepts occur.
    always_comb begin
        w_mem_rd    = 1'b0;
        w_mem_addr  = r_pc;
        w_instr_vld = 1'b0;
        case (r_state)
            S_REQ: begin
                w_mem_rd = fetch_en;
            end
            S_OPD: begin
                w_mem_rd   = fif.i_mem_data[7];
                w_mem_addr = r_pc + ADDR_W'(1);
            end
            S_OUT: begin
                w_instr_vld = 1'b1;
                w_mem_rd    = fif.decode_rdy & fetch_en;
                w_mem_addr  = w_next_addr;
            end
            default: ;
        endcase
        if (w_redirect || reset) begin
            w_mem_rd    = 1'b0;
            w_instr_vld = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc         <= RESET_PC;
            r_instr_addr <= RESET_PC;
            r_instr_op   <= 8'h00;
            r_instr_imm  <= 8'h00;
            r_instr_len2 <= 1'b0;
        end else if (w_redirect) begin
            r_pc <= w_redirect_addr;
        end else begin
            case (r_state)
                S_OPD: begin
                    r_instr_op   <= fif.i_mem_data;
                    r_instr_addr <= r_pc;
                    r_instr_len2 <= fif.i_mem_data[7];
                    if (!fif.i_mem_data[7]) r_instr_imm <= 8'h00;
                end
                S_IMMD: begin
                    r_instr_imm <= fif.i_mem_data;
                end
                S_OUT: begin
                    if (fif.decode_rdy) r_pc <= w_next_addr;
                end
                default: ;
            endcase
        end
    end

    assign fif.i_mem_rd   = w_mem_rd;
    assign fif.i_mem_addr = w_mem_addr;
    assign fif.instr_vld  = w_instr_vld;
    assign fif.instr_op   = r_instr_op;
    assign fif.instr_imm  = r_instr_imm;
    assign fif.instr_len2 = r_instr_len2;
    assign fif.instr_addr = r_instr_addr;
    assign fif.next_addr  = w_next_addr;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_fetch
//  Description : Directed self-checking bench for instr_fetch with a 1-cycle
//                memory model and an expected-instruction queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

    typedef struct packed {
        logic [7:0]  op;
        logic [7:0]  imm;
        logic        len2;
        logic [11:0] addr;
        logic [11:0] nxt;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_en;
    logic        pc_branch;
    logic [11:0] branch_addr;
    logic        ret_addr_en;
    logic [11:0] ret_addr;

    logic [7:0]  mem [0:4095];
    logic [7:0]  mem_q = 8'h00;
    int          rd_count = 0;

    int          vectors = 0;
    int          errors  = 0;
    exp_t        sb[$];

    instr_fetch_if #(.ADDR_W(12)) bus ();

    instr_fetch #(
        .ADDR_W   (12),
        .RESET_PC (12'h000)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .fetch_en    (fetch_en),
        .pc_branch   (pc_branch),
        .branch_addr (branch_addr),
        .ret_addr_en (ret_addr_en),
        .ret_addr    (ret_addr),
        .fif         (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.i_mem_rd) begin
            mem_q    <= mem[bus.i_mem_addr];
            rd_count <= rd_count + 1;
        end
    end
    assign bus.i_mem_data = mem_q;

    function automatic exp_t mk(input logic [7:0] op, input logic [7:0] imm,
                                input logic len2, input logic [11:0] addr,
                                input logic [11:0] nxt);
        exp_t e;
        e.op = op; e.imm = imm; e.len2 = len2; e.addr = addr; e.nxt = nxt;
        return e;
    endfunction

    function automatic exp_t obs();
        return mk(bus.instr_op, bus.instr_imm, bus.instr_len2,
                  bus.instr_addr, bus.next_addr);
    endfunction

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        vectors++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    task automatic wait_vld(input string tag, input int max, output int n);
        n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (!bus.instr_vld && n < max);
        if (!bus.instr_vld) chk({tag, "_timeout"}, 64'(bus.instr_vld), 64'(1));
    endtask

    task automatic check_head(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'(sb.size()), 64'(1));
        end else begin
            e = sb.pop_front();
            chk(tag, 64'(obs()), 64'(e));
        end
    endtask

    initial begin
        int   n;
        int   rd_snap;
        int   gaps[3];
        exp_t hold;
        gaps = '{2, 3, 2};

        reset = 1'b1; fetch_en = 1'b0; pc_branch = 1'b0; ret_addr_en = 1'b0;
        branch_addr = 12'h000; ret_addr = 12'h000; bus.decode_rdy = 1'b0;
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        mem[12'h000] = 8'h05; mem[12'h001] = 8'h83; mem[12'h002] = 8'h2A;
        mem[12'h003] = 8'h10; mem[12'h004] = 8'h07; mem[12'h005] = 8'h81;
        mem[12'h006] = 8'h55; mem[12'h4C0] = 8'h22; mem[12'h4C1] = 8'h03;
        mem[12'h100] = 8'h0A; mem[12'h101] = 8'h80; mem[12'hFFF] = 8'h9C;

        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk); #1;
        chk("rst_instr", 64'(obs()), 64'(mk(8'h00, 8'h00, 1'b0, 12'h000, 12'h001)));
        chk("rst_vld", 64'(bus.instr_vld), 64'(0));
        chk("rst_rd", 64'(bus.i_mem_rd), 64'(0));

        // Basic sequence with decode always ready
        sb.push_back(mk(8'h05, 8'h00, 1'b0, 12'h000, 12'h001));
        sb.push_back(mk(8'h83, 8'h2A, 1'b1, 12'h001, 12'h003));
        sb.push_back(mk(8'h10, 8'h00, 1'b0, 12'h003, 12'h004));
        fetch_en = 1'b1; bus.decode_rdy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_vld("seq", 10, n);
            check_head("seq_instr");
            chk("seq_gap", 64'(n), 64'(gaps[k]));
            @(posedge clk); #1;
        end

        // Decode stall for 5 cycles
        bus.decode_rdy = 1'b0;
        sb.push_back(mk(8'h07, 8'h00, 1'b0, 12'h004, 12'h005));
        wait_vld("stall", 10, n);
        hold = mk(8'h07, 8'h00, 1'b0, 12'h004, 12'h005);
        rd_snap = rd_count;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); #1;
            chk("stall_hold", 64'(obs()), 64'(hold));
            chk("stall_vld_rd", 64'({bus.instr_vld, bus.i_mem_rd}), 64'(2'b10));
        end
        chk("stall_rdcnt", 64'(rd_count), 64'(rd_snap));
        check_head("stall_instr");
        bus.decode_rdy = 1'b1; #1;
        chk("release_req", 64'({bus.i_mem_rd, bus.i_mem_addr}), 64'({1'b1, 12'h005}));
        @(posedge clk); #1;

        // Branch while the immediate byte is pending
        @(negedge clk); #1;
        chk("imm_req", 64'({bus.i_mem_rd, bus.i_mem_addr}), 64'({1'b1, 12'h006}));
        @(negedge clk);
        pc_branch = 1'b1; branch_addr = 12'h4C0; #1;
        chk("br_kill", 64'({bus.instr_vld, bus.i_mem_rd}), 64'(2'b00));
        @(posedge clk); #1;
        pc_branch = 1'b0;
        @(negedge clk); #1;
        chk("br_req", 64'({bus.i_mem_rd, bus.i_mem_addr}), 64'({1'b1, 12'h4C0}));
        sb.push_back(mk(8'h22, 8'h00, 1'b0, 12'h4C0, 12'h4C1));
        wait_vld("br", 10, n);
        chk("br_lat", 64'(n), 64'(2));
        check_head("br_instr");
        @(posedge clk); #1;

        // Simultaneous branch and return while an instruction is presented
        wait_vld("both_pre", 10, n);
        pc_branch = 1'b1; branch_addr = 12'h100;
        ret_addr_en = 1'b1; ret_addr = 12'h200; #1;
        chk("both_kill", 64'({bus.instr_vld, bus.i_mem_rd}), 64'(2'b00));
        @(posedge clk); #1;
        pc_branch = 1'b0; ret_addr_en = 1'b0;
        @(negedge clk); #1;
        chk("both_req", 64'({bus.i_mem_rd, bus.i_mem_addr}), 64'({1'b1, 12'h100}));
        sb.push_back(mk(8'h0A, 8'h00, 1'b0, 12'h100, 12'h101));
        wait_vld("both", 10, n);
        check_head("both_instr");
        @(posedge clk); #1;

        // Redirect in S_OPD with a 2-byte opcode returning: no second read
        pc_branch = 1'b1; branch_addr = 12'hFFF;
        @(negedge clk); #1;
        chk("opd_kill_rd", 64'(bus.i_mem_rd), 64'(0));
        @(posedge clk); #1;
        pc_branch = 1'b0;
        sb.push_back(mk(8'h9C, 8'h05, 1'b1, 12'hFFF, 12'h001));
        @(negedge clk); #1;
        chk("wrap_req0", 64'({bus.i_mem_rd, bus.i_mem_addr}), 64'({1'b1, 12'hFFF}));
        @(negedge clk); #1;
        chk("wrap_req1", 64'({bus.i_mem_rd, bus.i_mem_addr}), 64'({1'b1, 12'h000}));
        wait_vld("wrap2", 10, n);
        chk("wrap2_lat", 64'(n), 64'(2));
        check_head("wrap2_instr");
        @(posedge clk); #1;

        // 1-byte opcode at the top of memory
        mem[12'hFFF] = 8'h1C;
        pc_branch = 1'b1; branch_addr = 12'hFFF;
        @(posedge clk); #1;
        pc_branch = 1'b0;
        sb.push_back(mk(8'h1C, 8'h00, 1'b0, 12'hFFF, 12'h000));
        wait_vld("wrap1", 10, n);
        chk("wrap1_lat", 64'(n), 64'(3));
        check_head("wrap1_instr");
        @(posedge clk); #1;

        // Reset while an instruction is presented, then fetch disabled
        wait_vld("rst_pre", 10, n);
        reset = 1'b1; fetch_en = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk); #1;
        chk("rst2_vld_rd", 64'({bus.instr_vld, bus.i_mem_rd}), 64'(2'b00));
        chk("rst2_instr", 64'(obs()), 64'(mk(8'h00, 8'h00, 1'b0, 12'h000, 12'h001)));
        rd_snap = rd_count;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            chk("idle_rd", 64'(bus.i_mem_rd), 64'(0));
        end
        chk("idle_rdcnt", 64'(rd_count), 64'(rd_snap));
        fetch_en = 1'b1; #1;
        chk("restart_req", 64'({bus.i_mem_rd, bus.i_mem_addr}), 64'({1'b1, 12'h000}));
        chk("sb_drained", 64'(sb.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage of the 8-bit core, directly upstream of decode/execute. It owns the 12-bit program counter and reads 1- or 2-byte instructions from the byte-wide instruction memory. It presents each complete instruction to decode with a valid/ready handshake and supplies the return address used for CALL. It redirects the PC when execute signals `pc_branch` (JMP/CALL) or `ret_addr_en` (RET), discarding any in-flight fetch.

## Interface
- `ADDR_W`, 12, PC / instruction-memory address width
- `RESET_PC`, 12'h000, PC value after reset
- `clk`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `fetch_en`  in  1  run enable; low stalls new memory requests
- `i_mem_addr`  out  12  instruction memory byte address
- `i_mem_rd`  out  1  read request; `i_mem_data` valid the following cycle
- `i_mem_data`  in  8  read data
- `instr_vld`  out  1  complete instruction presented to decode
- `decode_rdy`  in  1  decode accepts the instruction this cycle
- `instr_op`  out  8  opcode byte
- `instr_imm`  out  8  second byte (immediate or address low byte); 0 for 1-byte instructions
- `instr_len2`  out  1  instruction is 2 bytes (`instr_op[7]` = 1)
- `instr_addr`  out  12  address of the presented opcode byte
- `next_addr`  out  12  `instr_addr + 1 + instr_len2`, mod 2^12; execute's return address
- `pc_branch`  in  1  redirect to `branch_addr`
- `branch_addr`  in  12  JMP/CALL target
- `ret_addr_en`  in  1  redirect to `ret_addr`
- `ret_addr`  in  12  RET target

## Operation
- States: S_REQ (issue opcode read), S_OPD (opcode data returning), S_IMMD (immediate data returning), S_OUT (instruction held for decode).
- Reset: state S_REQ, `pc` = RESET_PC, `instr_op`/`instr_imm`/`instr_len2` = 0, `instr_addr` = RESET_PC, `instr_vld` = 0, `i_mem_rd` = 0.
- S_REQ: if `fetch_en`, `i_mem_rd`=1, `i_mem_addr`=`pc`, go to S_OPD; otherwise stay with no request.
- S_OPD: capture `i_mem_data` into `instr_op`, and `pc` into `instr_addr`.
  - If `i_mem_data[7]`=1: issue read at `pc+1` in the same cycle, go to S_IMMD.
  - If `i_mem_data[7]`=0: set `instr_imm`=0, go to S_OUT.
- S_IMMD: capture `instr_imm`, go to S_OUT.
- S_OUT: `instr_vld`=1 (combinational kill, see redirect). On `decode_rdy`:
  - `pc` ← `next_addr`.
  - If `fetch_en`, issue the opcode read at `next_addr` in the same cycle and go to S_OPD; otherwise go to S_REQ.
  - Without `decode_rdy`, all outputs hold stable.
- Redirect: `pc_branch` or `ret_addr_en` in any state.
  - `pc` ← target (`pc_branch` wins if both are asserted).
  - State → S_REQ, and no memory request is issued that cycle.
  - Data returning next cycle is ignored.
  - `instr_vld` is forced 0 in the redirect cycle, so decode never accepts a wrong-path instruction.
- Arithmetic: all address increments are 12-bit and wrap. 0xFFF+1 = 0x000.
- `fetch_en` low in S_OPD/S_IMMD: the outstanding read still completes; it only suppresses the next new request.

## Timing
- Memory read latency is exactly 1 cycle. Requests are never pipelined deeper than 1.
- Latency from redirect to first `instr_vld`: 3 cycles for a 1-byte instruction (redirect, S_REQ, S_OPD, vld); 4 cycles for a 2-byte instruction.
- Back-to-back throughput with `decode_rdy` held high: one 1-byte instruction every 2 cycles; one 2-byte instruction every 3 cycles.
- `instr_*` and `next_addr` are stable whenever `instr_vld`=1 and not yet accepted.
- Reset asserted mid-operation: the next cycle shows reset values. Pending data is dropped.
- `i_mem_rd`/`i_mem_addr` are combinational from state, `pc`, `fetch_en`, `decode_rdy` and redirect inputs. No combinational path exists from `i_mem_data` to `i_mem_rd`; the exception is the opcode[7] → second-request path in S_OPD.

## Test plan
- Sequence 0x05, 0x83 0x2A, 0x10 at 0x000, with `decode_rdy`=1 → three accepted instructions:
  - {op 05, imm 00, addr 000, next 001}
  - {op 83, imm 2A, addr 001, next 003}
  - {op 10, addr 003}
  - Spacing is 2, 3 and 2 cycles.
- Hold `decode_rdy`=0 for 5 cycles in S_OUT → `instr_*` unchanged, no `i_mem_rd`. Release → accept, and the next read is at `next_addr`.
- `pc_branch`=1, `branch_addr`=0x4C0 while S_IMMD is pending → that cycle `instr_vld`=0 and the immediate is dropped. The next accepted instruction has `instr_addr`=0x4C0, and `i_mem_rd` is at 0x4C0 one cycle after the redirect.
- `pc_branch` and `ret_addr_en` together with `branch_addr`=0x100, `ret_addr`=0x200 → fetch resumes at 0x100.
- 2-byte opcode at 0xFFF → immediate read at 0x000, `next_addr`=0x001. A 1-byte opcode at 0xFFF gives `next_addr`=0x000.
- `reset` asserted in S_OUT with `instr_vld`=1 → the next cycle has `instr_vld`=0, and the first request after release is at RESET_PC. `fetch_en`=0 after reset → no `i_mem_rd` ever.
